// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU driven by the 4-bit ALUCtrl code.
//   Single-cycle ops (AND/OR/ADD/SUB/SLT/XOR/SLL and illegal codes) register
//   their result at the Start edge. MUL iterates shift-add over WIDTH cycles
//   with Busy high, then pulses Done.
// Ports:
//   Clock, Reset      - rising-edge clock, synchronous active-high reset
//   Start             - request, only sampled while Busy=0
//   ALUCtrl, A, B     - op code and operands, sampled with Start
//   Busy              - high while a MUL is iterating
//   Done              - one-cycle pulse when Result and flags update
//   Result, Zero,
//   Overflow, Illegal - registered result and flags, held between Dones
module alu_exec_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       ALUCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             Illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b1010;
    localparam logic [3:0] OP_SLT = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b0100;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           r_state, w_state_nxt;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_zero, r_ovf, r_ill, r_done;

    logic             w_accept, w_is_mul, w_last;
    logic [WIDTH-1:0] w_sum, w_diff, w_res, w_acc_nxt;
    logic             w_ovf, w_ill;

    assign w_accept  = Start && (r_state == S_IDLE);
    assign w_is_mul  = (ALUCtrl == OP_MUL);
    // Counter runs 0..WIDTH-1; the final iteration also commits the result,
    // which makes Busy exactly WIDTH cycles long.
    assign w_last    = (r_state == S_MUL) && (r_cnt == SHW'(WIDTH - 1));
    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    assign w_sum  = A + B;
    assign w_diff = A - B;

    // Single-cycle result decode
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        case (ALUCtrl)
            OP_AND: w_res = A & B;
            OP_OR:  w_res = A | B;
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_XOR: w_res = A ^ B;
            OP_SLL: w_res = A << B[SHW-1:0];
            OP_MUL: w_res = '0;  // never committed from here; MUL goes iterative
            default: w_ill = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge Clock) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_is_mul) w_state_nxt = S_MUL;
            S_MUL:  if (w_last)               w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_ill    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        r_mcand  <= A;
                        r_mplier <= B;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end else begin
                        r_result <= w_res;
                        r_zero   <= (w_res == '0);
                        r_ovf    <= w_ovf;
                        r_ill    <= w_ill;
                        r_done   <= 1'b1;
                    end
                end
            end else begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + SHW'(1);
                if (w_last) begin
                    r_result <= w_acc_nxt;
                    r_zero   <= (w_acc_nxt == '0);
                    r_ovf    <= 1'b0;
                    r_ill    <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign Busy     = (r_state == S_MUL);
    assign Done     = r_done;
    assign Result   = r_result;
    assign Zero     = r_zero;
    assign Overflow = r_ovf;
    assign Illegal  = r_ill;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit (WIDTH=16). The driver pushes the
// hand-computed response and the cycle it must appear on; a monitor on the
// falling edge pops and compares whenever Done is high.
module tb_alu_exec_unit;

    localparam int W = 16;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b1010;
    localparam logic [3:0] C_SLT = 4'b0011;
    localparam logic [3:0] C_XOR = 4'b0101;
    localparam logic [3:0] C_SLL = 4'b0110;
    localparam logic [3:0] C_MUL = 4'b0100;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic [3:0]   ALUCtrl = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Busy, Done, Zero, Overflow, Illegal;
    logic [W-1:0] Result;

    alu_exec_unit #(.WIDTH(W)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .ALUCtrl(ALUCtrl),
        .A(A), .B(B), .Busy(Busy), .Done(Done), .Result(Result),
        .Zero(Zero), .Overflow(Overflow), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [W-1:0] res;
        logic         z, o, il;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   busy_run = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: Done-driven scoreboard pops plus Busy run-length check
    always @(negedge Clock) begin
        if (Reset) begin
            busy_run = 0;
        end else begin
            if (Busy) busy_run++;
            else if (busy_run != 0) begin
                chk("busy_len", busy_run, W);
                busy_run = 0;
            end
            if (Done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("result", {16'h0, Result}, {16'h0, e.res});
                    chk("zero", {31'h0, Zero}, {31'h0, e.z});
                    chk("overflow", {31'h0, Overflow}, {31'h0, e.o});
                    chk("illegal", {31'h0, Illegal}, {31'h0, e.il});
                end
            end
        end
    end

    task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [W-1:0] r,
                         input logic z, input logic o, input logic il);
        exp_t e;
        @(posedge Clock); #1;
        Start = 1'b1; ALUCtrl = c; A = a; B = b;
        if (push) begin
            e.res = r; e.z = z; e.o = o; e.il = il;
            e.cyc = cyc + 1 + ((c == C_MUL) ? W : 0);
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clock); #1;
            Start = 1'b0;
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"},   {31'h0, Busy},     32'd0);
        chk({tag, "_done"},   {31'h0, Done},     32'd0);
        chk({tag, "_result"}, {16'h0, Result},   32'd0);
        chk({tag, "_zero"},   {31'h0, Zero},     32'd1);
        chk({tag, "_ovf"},    {31'h0, Overflow}, 32'd0);
        chk({tag, "_ill"},    {31'h0, Illegal},  32'd0);
    endtask

    initial begin
        repeat (3) @(posedge Clock);
        #1;
        chk_reset_state("rst");
        Reset = 1'b0;

        // MUL 7*9, then an ADD accepted in the same cycle Done is high
        issue(C_MUL, 16'd7, 16'd9, 1, 16'd63, 1'b0, 1'b0, 1'b0);
        idle(W);
        issue(C_ADD, 16'h7FFF, 16'h0001, 1, 16'h8000, 1'b0, 1'b1, 1'b0);
        // Back-to-back single-cycle ops with Start held high
        issue(C_SUB, 16'd5,    16'd5,    1, 16'h0000, 1'b1, 1'b0, 1'b0);
        issue(C_SUB, 16'h8000, 16'h0001, 1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        issue(C_ADD, 16'hFFFF, 16'h0001, 1, 16'h0000, 1'b1, 1'b0, 1'b0);
        issue(C_SLT, 16'hFFFF, 16'h0001, 1, 16'h0001, 1'b0, 1'b0, 1'b0);
        issue(C_SLT, 16'h0001, 16'hFFFF, 1, 16'h0000, 1'b1, 1'b0, 1'b0);
        issue(C_SLL, 16'h0003, 16'h0004, 1, 16'h0030, 1'b0, 1'b0, 1'b0);
        issue(C_XOR, 16'h00FF, 16'h0F0F, 1, 16'h0FF0, 1'b0, 1'b0, 1'b0);
        issue(C_AND, 16'hF0F0, 16'h3C3C, 1, 16'h3030, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Truncating MUL with Start pulses during Busy that must be ignored
        issue(C_MUL, 16'hFFFF, 16'h0002, 1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= W + 2; i++) begin
            @(posedge Clock); #1;
            Start   = (i == 3 || i == 8);
            ALUCtrl = C_ADD;
            A       = 16'h0101 * i[15:0];
            B       = 16'h0001;
        end
        idle(2);

        // Reset mid-MUL: no Done, outputs back to reset values
        issue(C_MUL, 16'd3, 16'd4, 0, 16'h0, 1'b0, 1'b0, 1'b0);
        idle(4);
        @(posedge Clock); #1;
        Reset = 1'b1; Start = 1'b0;
        @(posedge Clock); #1;
        chk_reset_state("abort");
        Reset = 1'b0;
        issue(C_ADD, 16'd2, 16'd3, 1, 16'd5, 1'b0, 1'b0, 1'b0);

        // Illegal codes and recovery
        issue(4'b1111, 16'h1234, 16'h5678, 1, 16'h0000, 1'b1, 1'b0, 1'b1);
        issue(C_OR,    16'h0F00, 16'h00F0, 1, 16'h0FF0, 1'b0, 1'b0, 1'b0);
        issue(4'b1011, 16'h8000, 16'h8000, 1, 16'h0000, 1'b1, 1'b0, 1'b1);
        idle(3);

        // Input changes without Start must not produce a Done
        ALUCtrl = C_ADD; A = 16'h1111; B = 16'h2222;
        idle(3);

        begin
            int guard = 0;
            while (sb.size() != 0 && guard < 100) begin
                @(posedge Clock);
                guard++;
            end
        end
        @(negedge Clock);
        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
